// File: rtl/present80_serial_engine_if.sv
// Bus between the nibble-bus register front end and the PRESENT-80 engine.
// Optional macro PRESENT_ROUNDCNT_EN adds the Round_ob progress field.
interface present80_serial_engine_if;
    logic [63:0] PlainText_ib;
    logic [79:0] Key_ib;
    logic        Start_i;
    logic [63:0] CipherText_ob;
    logic        Ready_o;
`ifdef PRESENT_ROUNDCNT_EN
    logic [4:0]  Round_ob;
`endif

    // Front end side: drives operands and start, reads result and status.
    modport master (
        output PlainText_ib, Key_ib, Start_i,
`ifdef PRESENT_ROUNDCNT_EN
        input  Round_ob,
`endif
        input  CipherText_ob, Ready_o
    );

    // Engine side.
    modport slave (
        input  PlainText_ib, Key_ib, Start_i,
`ifdef PRESENT_ROUNDCNT_EN
        output Round_ob,
`endif
        output CipherText_ob, Ready_o
    );
endinterface

// File: rtl/present80_serial_engine.sv
// Nibble-serial PRESENT-80 encryption engine.
// One shared state S-box walks the 64-bit state a nibble per cycle; the key
// schedule has its own S-box and updates in the permutation cycle.
// Round timing: ADDKEY (1) + SBOX (16) + PERM (1) = 18 cycles per round,
// plus one FINAL cycle for the closing key whitening.
// Optional macro PRESENT_ROUNDCNT_EN exports the round counter as Round_ob.
module present80_serial_engine #(
    parameter int ROUNDS = 31
) (
    input logic                      Clk_ik,
    input logic                      Reset_ir,
    present80_serial_engine_if.slave bus
);

    localparam logic [4:0] LAST_ROUND = ROUNDS[4:0];

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDKEY = 3'd1,
        SBOX   = 3'd2,
        PERM   = 3'd3,
        FINAL  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] st_q,    st_d;
    logic [79:0] key_q,   key_d;
    logic [4:0]  round_q, round_d;
    logic [3:0]  nib_q,   nib_d;
    logic [63:0] ct_q,    ct_d;
    logic        ready_q, ready_d;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // Bit permutation: bit i lands at 16*i mod 63, bit 63 is fixed.
    function automatic logic [63:0] player(input logic [63:0] s);
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < 63; i++) begin
            p[(16 * i) % 63] = s[i];
        end
        p[63] = s[63];
        return p;
    endfunction

    // Key schedule step using the counter of the round just completed.
    function automatic logic [79:0] key_update(input logic [79:0] k,
                                               input logic [4:0]  rnd);
        logic [79:0] kr;
        kr          = {k[18:0], k[79:19]};
        kr[79:76]   = sbox(kr[79:76]);
        kr[19:15]   = kr[19:15] ^ rnd;
        return kr;
    endfunction

    // State register and datapath registers; reset aborts any run in flight.
    always_ff @(posedge Clk_ik) begin
        if (Reset_ir) begin
            state_q <= IDLE;
            st_q    <= '0;
            key_q   <= '0;
            round_q <= '0;
            nib_q   <= '0;
            ct_q    <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            key_q   <= key_d;
            round_q <= round_d;
            nib_q   <= nib_d;
            ct_q    <= ct_d;
            ready_q <= ready_d;
        end
    end

    // Next-state sequencing; Start_i only matters in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.Start_i) state_d = ADDKEY;
            ADDKEY:  state_d = SBOX;
            SBOX:    if (nib_q == 4'hF) state_d = PERM;
            PERM:    state_d = (round_q == LAST_ROUND) ? FINAL : ADDKEY;
            FINAL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output updates per state; everything holds by default.
    always_comb begin
        st_d    = st_q;
        key_d   = key_q;
        round_d = round_q;
        nib_d   = nib_q;
        ct_d    = ct_q;
        ready_d = ready_q;
        case (state_q)
            IDLE: begin
                if (bus.Start_i) begin
                    st_d    = bus.PlainText_ib;
                    key_d   = bus.Key_ib;
                    round_d = 5'd1;
                    nib_d   = 4'd0;
                    ready_d = 1'b0;
                end
            end
            ADDKEY: begin
                st_d = st_q ^ key_q[79:16];
            end
            SBOX: begin
                // Rotate right by a nibble; the substituted low nibble enters
                // at the top, so 16 steps restore the original order.
                st_d  = {sbox(st_q[3:0]), st_q[63:4]};
                nib_d = nib_q + 4'd1;
            end
            PERM: begin
                st_d  = player(st_q);
                key_d = key_update(key_q, round_q);
                if (round_q != LAST_ROUND) round_d = round_q + 5'd1;
            end
            FINAL: begin
                ct_d    = st_q ^ key_q[79:16];
                ready_d = 1'b1;
                round_d = 5'd0;
            end
            default: ;
        endcase
    end

    assign bus.CipherText_ob = ct_q;
    assign bus.Ready_o       = ready_q;
`ifdef PRESENT_ROUNDCNT_EN
    assign bus.Round_ob      = round_q;
`endif

endmodule
